// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if -- signal bundle for the two-requester Ethernet TX scheduler.
//   Requester side : a_/b_valid, a_/b_data, a_/b_last in; a_/b_ready back.
//   Serializer side: axiov/axiod byte stream, grant owner, busy, err pulse.
//   master: drives the requester inputs and observes everything else.
//   slave : the scheduler itself.
interface eth_tx_sched_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic       axiov;
  logic [7:0] axiod;
  logic [1:0] grant;
  logic       busy;
  logic       err;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last,
    input  a_ready, b_ready, axiov, axiod, grant, busy, err
  );

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last,
    output a_ready, b_ready, axiov, axiod, grant, busy, err
  );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched -- round-robin frame scheduler feeding a dibit serializer.
// Each byte slot lasts 4 clk cycles (phase 0..3). A frame is PREAMBLE_BYTES of
// 0x55, one 0xD5, then payload pulled from the granted requester, followed by
// IFG_CYCLES idle cycles.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : eth_tx_sched_if.slave (requester handshakes, axiov/axiod, grant,
//              busy, err)
//
// state | meaning
// IDLE  | no frame; waiting for a request
// PRE   | sending preamble bytes (0x55)
// SFD   | sending start-of-frame delimiter (0xD5)
// PAY   | sending payload bytes
// IFG   | inter-frame gap, axiov low, grant still held
module eth_tx_sched #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_CYCLES     = 48,
  parameter int MAX_BYTES      = 1522
) (
  input logic           clk,
  input logic           rst,
  eth_tx_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_IFG  = 3'd4;

  // One counter is shared: preamble down-count, payload up-count, IFG down-count.
  localparam int CW = $clog2(MAX_BYTES + PREAMBLE_BYTES + IFG_CYCLES + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_BYTES - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [2:0]    state;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic          last_done;
  logic          prio_b;
  logic          axiov_q;
  logic [7:0]    axiod_q;
  logic [1:0]    grant_q;
  logic          err_q;

  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          slot_end;
  logic          at_max;
  logic          xfer_slot;

  always_comb begin
    sel_valid = grant_q[1] ? bus.b_valid : bus.a_valid;
    sel_data  = grant_q[1] ? bus.b_data  : bus.a_data;
    sel_last  = grant_q[1] ? bus.b_last  : bus.a_last;
    slot_end  = (phase == 2'd3);
    // Once MAX_BYTES are out, the last slot of that byte must not pull another.
    at_max    = (state == S_PAY) && (cnt == MAX_CNT);
    xfer_slot = ((state == S_SFD) || (state == S_PAY)) && slot_end &&
                !last_done && !at_max;
  end

  assign bus.a_ready = xfer_slot & grant_q[0];
  assign bus.b_ready = xfer_slot & grant_q[1];
  assign bus.axiov   = axiov_q;
  assign bus.axiod   = axiod_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state != S_IDLE);
  assign bus.err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      cnt       <= '0;
      last_done <= 1'b0;
      prio_b    <= 1'b0;
      axiov_q   <= 1'b0;
      axiod_q   <= 8'h00;
      grant_q   <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.a_valid || bus.b_valid) begin
            // prio_b set means B won't lose a tie: A was the last owner.
            if (bus.a_valid && (!bus.b_valid || !prio_b)) begin
              grant_q <= 2'b01;
              prio_b  <= 1'b1;
            end else begin
              grant_q <= 2'b10;
              prio_b  <= 1'b0;
            end
            state     <= S_PRE;
            phase     <= 2'd0;
            cnt       <= PRE_LAST;
            last_done <= 1'b0;
            axiov_q   <= 1'b1;
            axiod_q   <= 8'h55;
          end
        end
        S_PRE: begin
          phase <= phase + 2'd1;
          if (slot_end) begin
            if (cnt == '0) begin
              state   <= S_SFD;
              axiod_q <= 8'hD5;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        S_SFD, S_PAY: begin
          phase <= phase + 2'd1;
          if (slot_end) begin
            if (last_done) begin
              state   <= S_IFG;
              phase   <= 2'd0;
              cnt     <= IFG_LAST;
              axiov_q <= 1'b0;
            end else if (!at_max && sel_valid) begin
              // cnt is 0 on leaving SFD, so it becomes the payload byte count.
              state     <= S_PAY;
              cnt       <= cnt + ONE;
              axiod_q   <= sel_data;
              last_done <= sel_last;
            end else begin
              // underrun or overlength: abort, axiod keeps its last value
              state   <= S_IFG;
              phase   <= 2'd0;
              cnt     <= IFG_LAST;
              axiov_q <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        S_IFG: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            grant_q <= 2'b00;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 SHALL have parameter PREAMBLE_BYTES, default 7, number of 0x55 preamble bytes per frame.
REQ-002 SHALL have parameter IFG_CYCLES, default 48, idle clk cycles between frames (12 byte times x 4).
REQ-003 SHALL have parameter MAX_BYTES, default 1522, payload byte limit per frame.
REQ-004 SHALL have port clk  in  1  clock; rising-edge only.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_valid/b_valid  in  1  requester A/B has a payload byte available.
REQ-007 SHALL have ports a_data/b_data  in  8  requester A/B payload byte.
REQ-008 SHALL have ports a_last/b_last  in  1  current byte is the final byte of the frame.
REQ-009 SHALL have ports a_ready/b_ready  out  1  combinational; byte transferred when valid&&ready.
REQ-010 SHALL have port axiov  out  1  registered; byte stream valid to the dibit serializer.
REQ-011 SHALL have port axiod  out  8  registered; byte to serializer, held 4 cycles per byte.
REQ-012 SHALL have port grant  out  2  registered one-hot owner of the current frame ({B,A}); 00 when idle.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port err  out  1  one-cycle pulse on underrun or overlength abort.

Function
REQ-015 SHALL implement states IDLE, PRE, SFD, PAY, IFG with a 2-bit phase counter (0..3) per byte slot.
REQ-016 SHALL, in IDLE with any valid high, select a requester, set grant, enter PRE, and drive axiov=1, axiod=0x55, phase=0 on the next cycle.
REQ-017 SHALL arbitrate round-robin: requester not granted last wins on simultaneous requests; after reset A has priority.
REQ-018 SHALL hold axiod constant for exactly 4 consecutive cycles per byte with axiov continuously high from first preamble byte through last payload byte.
REQ-019 SHALL emit PREAMBLE_BYTES bytes of 0x55, then one byte 0xD5 in SFD, then payload in PAY.
REQ-020 SHALL assert the granted requester's ready only when state is SFD or PAY, phase==3, and the last byte has not yet been transferred; non-granted ready is always 0.
REQ-021 SHALL load the transferred byte into axiod on the edge following the ready cycle, so payload byte n appears immediately after byte n-1's fourth cycle.
REQ-022 SHALL, after the 4th cycle of the byte transferred with last=1, drive axiov=0 and enter IFG.
REQ-023 SHALL treat granted valid low at a ready cycle as underrun: next cycle axiov=0, err=1 for one cycle, enter IFG.
REQ-024 SHALL count payload bytes; when MAX_BYTES have been sent without last, abort as in REQ-023 after that byte's 4th cycle.
REQ-025 SHALL stay in IFG for exactly IFG_CYCLES cycles with axiov=0, then return to IDLE and clear grant; requests during IFG are ignored.
REQ-026 SHALL ignore non-granted requester inputs for the whole frame.
REQ-027 SHALL keep axiod unchanged while axiov=0.

Reset
REQ-028 SHALL, while rst is high, force state IDLE, axiov=0, axiod=0x00, grant=00, busy=0, err=0, phase=0, byte count=0, priority to A.
REQ-029 SHALL, on rst mid-frame, drop axiov on the next edge with no IFG and no err pulse.

Verification
REQ-030 SHALL cover single frame from A, bytes 0x11,0x22,0x33(last) -> axiov high 44 cycles: 28 of 0x55, 4 of 0xD5, 4 each of 0x11/0x22/0x33; a_ready pulses 3 times; then 48 idle cycles.
REQ-031 SHALL cover A and B valid in the same IDLE cycle after reset -> A frame first, B frame starts exactly IFG_CYCLES+1 cycles after A's axiov falls.
REQ-032 SHALL cover a_valid dropped at 2nd payload ready cycle -> axiov low next cycle, err one-cycle pulse, IFG entered, grant=00 after 48 cycles.
REQ-033 SHALL cover MAX_BYTES=4 with 6-byte stream lacking last -> exactly 4 payload bytes emitted, err pulse, a_ready pulses 4 times.
REQ-034 SHALL cover rst asserted during PRE -> next cycle axiov=0, busy=0, grant=00, err=0; new request starts fresh preamble.
REQ-035 SHALL cover B requesting during A's IFG -> b_ready stays 0 until B granted from IDLE.
